// File: rtl/output_port_fifo.sv
// output_port_fifo: credit-returning receive buffer at a DySER output port.
// Accepts path tokens from the upstream switch/FU stage and presents them
// to the processor as a first-word-fall-through FIFO. Every drained entry
// returns one credit to the upstream. Configuration mode flushes the buffer
// and silences both the push and pop sides.

`ifndef PATH_WIDTH
`define PATH_WIDTH 33
`endif
`ifndef META_BITS
`define META_BITS 2
`endif

module output_port_fifo #(
    parameter int ID    = 0,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`PATH_WIDTH:0]  d_in,
    output logic                  c_out,
    input  logic                  conf_en,
    input  logic                  rd_en,
    output logic [31:0]           rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int WORD_W = 33;

    // ID only tags the port for tracing; it takes part in the parameter
    // sanity check so an out-of-range configuration fails at elaboration.
    generate
        if ((ID < 0) || (DEPTH < 2) || (DEPTH > 16) ||
            ((DEPTH & (DEPTH - 1)) != 0) || (CNT_W < PTR_W + 1)) begin : g_bad_param
            $error("output_port_fifo: illegal DEPTH/CNT_W/ID combination");
        end
    endgenerate

    // Storage and state
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_c_out;

    // Decoded control
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_wr_en;
    logic              w_ovf_evt;
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_head;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));

    // A token is present when its ready bit is set; configuration mode
    // blocks both sides so the flush sees no competing traffic.
    assign w_push    = d_in[0] & ~conf_en;
    assign w_pop     = rd_en & ~w_empty & ~conf_en;

    // When full, a push is only accepted if a pop frees the head slot in
    // the same cycle; otherwise the token is dropped and flagged.
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_ovf_evt = w_push & w_full & ~w_pop;

    // Predicated-off tokens (valid=0) are stored like any other so that
    // they still consume and later return a credit.
    assign w_wr_word = {d_in[`PATH_WIDTH:`META_BITS], d_in[1]};

    // Token storage write port; contents need no reset since the pointers
    // and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    // Pointer, occupancy and overflow tracking, with synchronous flush in
    // configuration mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (conf_en) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Credit return: one registered pulse per pop. w_pop is already
    // suppressed during configuration, so no credit leaks out then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_out <= 1'b0;
        end else begin
            r_c_out <= w_pop;
        end
    end

    // First-word-fall-through head view, forced to zero when empty.
    assign w_head   = r_mem[r_rd_ptr];
    assign rd_data  = w_empty ? 32'd0 : w_head[WORD_W-1:1];
    assign rd_valid = w_empty ? 1'b0  : w_head[0];

    assign empty    = w_empty;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign c_out    = r_c_out;

endmodule

// File: tb/tb_output_port_fifo.sv
// Self-checking bench for output_port_fifo: a queue scoreboard holds the
// tokens expected to be stored; each pop compares the head against it, and
// after every edge the occupancy flags, overflow and credit are compared.

`ifndef PATH_WIDTH
`define PATH_WIDTH 33
`endif
`ifndef META_BITS
`define META_BITS 2
`endif

module tb_output_port_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic                 clk;
    logic                 rst_n;
    logic [`PATH_WIDTH:0] d_in;
    logic                 c_out;
    logic                 conf_en;
    logic                 rd_en;
    logic [31:0]          rd_data;
    logic                 rd_valid;
    logic                 empty;
    logic                 full;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    output_port_fifo #(.ID(0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_in     (d_in),
        .c_out    (c_out),
        .conf_en  (conf_en),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and reference state
    logic [32:0] sb_q[$];
    logic        ovf_m;
    logic        exp_cout;
    int          n_checks;
    int          n_pass;
    int          n_credits;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every observable output against the reference state.
    task automatic check_state(input string ctx);
        logic [32:0] head;
        head = (sb_q.size() > 0) ? sb_q[0] : 33'd0;
        check({ctx, ".count"},    64'(count),    64'(sb_q.size()));
        check({ctx, ".empty"},    64'(empty),    64'(sb_q.size() == 0));
        check({ctx, ".full"},     64'(full),     64'(sb_q.size() == DEPTH));
        check({ctx, ".overflow"}, 64'(overflow), 64'(ovf_m));
        check({ctx, ".c_out"},    64'(c_out),    64'(exp_cout));
        check({ctx, ".rd_data"},  64'(rd_data),  64'(head[32:1]));
        check({ctx, ".rd_valid"}, 64'(rd_valid), 64'(head[0]));
    endtask

    // One clock cycle of stimulus. Entered and left at posedge+1.
    task automatic step(input logic rdy, input logic [31:0] dat, input logic vld,
                        input logic rd, input logic conf, input string ctx);
        logic        pop_m;
        logic        ovf_evt;
        logic        push_m;
        logic [32:0] h;
        d_in    = {dat, vld, rdy};
        rd_en   = rd;
        conf_en = conf;
        #1;
        pop_m   = rd && !conf && (sb_q.size() > 0);
        ovf_evt = rdy && !conf && (sb_q.size() == DEPTH) && !pop_m;
        push_m  = rdy && !conf && !ovf_evt;
        if (pop_m) begin
            h = sb_q.pop_front();
            check({ctx, ".pop_data"},  64'(rd_data),  64'(h[32:1]));
            check({ctx, ".pop_valid"}, 64'(rd_valid), 64'(h[0]));
            n_credits++;
        end
        if (conf) begin
            sb_q.delete();
            ovf_m = 1'b0;
        end else begin
            if (push_m) sb_q.push_back({dat, vld});
            if (ovf_evt) ovf_m = 1'b1;
        end
        exp_cout = pop_m;
        @(posedge clk);
        #1;
        $display("step %-8s rdy=%0b dat=%08h vld=%0b rd=%0b conf=%0b -> count=%0d rd_data=%08h c_out=%0b ovf=%0b",
                 ctx, rdy, dat, vld, rd, conf, count, rd_data, c_out, overflow);
        check_state(ctx);
    endtask

    task automatic push(input logic [31:0] dat, input string ctx);
        step(1'b1, dat, 1'b1, 1'b0, 1'b0, ctx);
    endtask

    task automatic pop(input string ctx);
        step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, ctx);
    endtask

    task automatic idle(input string ctx);
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ctx);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_credits = 0;
        ovf_m     = 1'b0;
        exp_cout  = 1'b0;
        rst_n     = 1'b0;
        d_in      = '0;
        conf_en   = 1'b0;
        rd_en     = 1'b0;

        // Reset held for two cycles with idle inputs
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            $display("reset cycle %0d count=%0d empty=%0b", i, count, empty);
            check_state("reset");
        end
        rst_n = 1'b1;
        idle("idle");

        // Single token, then drain it
        push(32'hDEADBEEF, "single");
        pop("single_p");
        idle("credit_end");

        // Fill, partial drain, refill across the wrap point, drain
        for (int i = 1; i <= 4; i++) push(32'(i), "fill");
        pop("wrap_p");
        pop("wrap_p");
        push(32'd5, "wrap");
        push(32'd6, "wrap");
        for (int i = 0; i < 4; i++) pop("wrap_p");
        idle("wrap_end");

        // Full with simultaneous push+pop, then an overflowing push
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(i), "fill2");
        step(1'b1, 32'd7, 1'b1, 1'b1, 1'b0, "full_pp");
        push(32'h99, "ovf");
        for (int i = 0; i < 4; i++) pop("drain2");

        // Predicated-off token is stored and still returns a credit
        step(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, "pred");
        pop("pred_p");

        // Config flush with 3 entries and overflow set
        for (int i = 0; i < 5; i++) push(32'h20 + 32'(i), "prefl");
        pop("prefl_p");
        step(1'b1, 32'hAAAA, 1'b1, 1'b1, 1'b1, "conf");
        step(1'b1, 32'hBBBB, 1'b1, 1'b1, 1'b1, "conf");
        push(32'h30, "postcfg");
        pop("postcfg_p");

        // Random traffic including occasional configuration
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "rand");
        end

        // Asynchronous reset mid-cycle clears state without a clock edge
        push(32'h40, "prerst");
        push(32'h41, "prerst");
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        ovf_m    = 1'b0;
        exp_cout = 1'b0;
        $display("async reset count=%0d empty=%0b rd_data=%08h", count, empty, rd_data);
        check_state("arst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'h50, "postrst");
        pop("postrst_p");
        idle("end");

        check("credit_total", 64'(n_credits) != 0, 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/output_port_fifo.md
Name: output_port_fifo

Overview:
- Credit-returning receive buffer at a DySER output port.
- Sits directly downstream of a functional unit / switch stage SE output. Consumes its {data, valid, ready} path tokens and returns one credit per drained entry on its credit output.
- Presents a first-word-fall-through FIFO to the processor-side output interface.
- Flushed and held silent while the fabric is being configured.

Parameters:
- ID, 0, port identifier; debug/trace only, no functional effect.
- DEPTH, 4, number of token entries (power of two, 2..16). The upstream credit counter's initial value equals DEPTH.
- CNT_W, 3, width of the count output; must hold DEPTH (log2(DEPTH)+1).

Ports:
- clk  in  1  fabric clock
- rst_n  in  1  asynchronous active-low reset
- d_in  in  `PATH_WIDTH+1  upstream token
  - [`PATH_WIDTH:`META_BITS] = 32-bit data
  - [1] = valid
  - [0] = ready (token present this cycle)
- c_out  out  1  credit pulse to upstream, one per freed entry
- conf_en  in  1  fabric configuration mode
- rd_en  in  1  processor pop request
- rd_data  out  32  head entry data
- rd_valid  out  1  head entry valid (predicate) bit
- empty  out  1  no entries stored
- full  out  1  count == DEPTH
- count  out  CNT_W  entries stored
- overflow  out  1  sticky: a token arrived while full with no pop

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: pointers, count, c_out, overflow = 0; empty = 1; full = 0; rd_data and rd_valid = 0.
- Storage: DEPTH x 33 bits, holding {data, valid}. The ready bit is not stored.
- Write: push = d_in[0] & ~conf_en. A push writes {d_in[`PATH_WIDTH:`META_BITS], d_in[1]} at the write pointer.
  - Tokens with valid=0 are still stored; they carry a predicated-off result and still consume and return a credit.
- Read: pop = rd_en & ~empty & ~conf_en.
  - rd_data/rd_valid show the head entry combinationally (FWFT) whenever empty = 0; both are 0 when empty.
  - A pop advances the read pointer at the clock edge.
- Latency: a token pushed at edge N is visible on rd_data after edge N; one cycle push-to-read.
- Credit: c_out is registered and equals pop delayed one cycle. It is asserted exactly one cycle per pop and never asserted otherwise.
- Simultaneous events:
  - Push + pop when not empty: count unchanged, both pointers advance.
  - Push + pop when full: legal; count stays DEPTH, no overflow.
  - Push when empty with rd_en: the pop is ignored (empty); the push is stored.
  - Push when full without pop: data dropped, count unchanged, overflow set to 1. overflow clears only on reset or conf_en.
- Pointers: modulo DEPTH, wrap silently. count = number of pushes minus number of pops.
- conf_en = 1:
  - Synchronous flush: pointers, count and overflow clear at the next edge.
  - c_out held 0 (the upstream credit counter is reinitialised by configuration).
  - push and pop suppressed.
  - Normal operation resumes on the first edge after conf_en falls.
- Reset mid-operation: all state clears immediately (asynchronous); the stored entries are lost.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, inputs 0 -> empty=1, full=0, count=0, c_out=0, rd_data=0 throughout.
- Single token: d_in = {32'hDEADBEEF, valid 1, ready 1} for one cycle.
  - Next cycle: rd_data=DEADBEEF, rd_valid=1, count=1.
  - rd_en for 1 cycle: empty=1 after the edge, c_out=1 for exactly one cycle, the cycle after the pop edge.
- Fill and wrap: push tokens 1..4 (DEPTH=4) -> full=1, count=4. Then pop 2, push 5,6, pop 4 -> rd_data sequence 1,2,3,4,5,6; 6 credit pulses total; overflow=0.
- Full with simultaneous push+pop: at count=4, push 7 while popping -> count stays 4, overflow=0. Then a push without pop -> overflow=1, count=4, the pushed data is never read.
- Predicated-off token: push {32'h5, valid 0, ready 1} -> stored, rd_valid=0, rd_data=5. The pop returns a credit.
- Config flush: with 3 entries and overflow=1, raise conf_en for 2 cycles with d_in[0]=1 and rd_en=1 -> count=0, empty=1, overflow=0, c_out stays 0, nothing stored. After conf_en falls, a push is accepted normally.
